// File: rtl/viterbi_dec_k3.sv
// Hard-decision Viterbi decoder for the rate-1/2 K=3 (7,5) code.
// 4-state ACS with subtract-min normalisation and register-exchange survivors.
module viterbi_dec_k3 #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic din_valid,
    input  logic frame_start,
    output logic dout,
    output logic dout_valid
);

    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0] PM_MAX = '1;

    logic                r_phase;
    logic                r_r0;
    logic [CNT_W-1:0]    r_sym_cnt;
    logic [PM_W-1:0]     r_pm   [4];
    logic [TB_DEPTH-1:0] r_path [4];
    logic                r_dout;
    logic                r_dout_valid;

    logic                w_restart;
    logic                w_trig;
    logic                w_emit;
    logic [PM_W-1:0]     w_pm_raw   [4];
    logic [PM_W-1:0]     w_pm_new   [4];
    logic [PM_W-1:0]     w_pm_min;
    logic [TB_DEPTH-1:0] w_path_new [4];
    logic [1:0]          w_best;

    function automatic logic [1:0] branch_metric(input logic [1:0] p, input logic x,
                                                 input logic rx0, input logic rx1);
        logic g0;
        logic g1;
        g0 = x ^ p[1] ^ p[0];
        g1 = x ^ p[1];
        return {1'b0, rx0 ^ g0} + {1'b0, rx1 ^ g1};
    endfunction

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
        logic [PM_W:0] s;
        s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
        return s[PM_W] ? PM_MAX : s[PM_W-1:0];
    endfunction

    assign w_restart = din_valid & frame_start;
    assign w_trig    = din_valid & ~frame_start & r_phase;
    assign w_emit    = w_trig & ((r_sym_cnt == CNT_W'(TB_DEPTH - 1)) ||
                                 (r_sym_cnt == CNT_W'(TB_DEPTH)));

    // Predecessors of ns are {0,ns[1]} and {1,ns[1]}; ties keep the lower index.
    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam logic [1:0] NS = 2'(g);
        localparam logic [1:0] P0 = {1'b0, NS[1]};
        localparam logic [1:0] P1 = {1'b1, NS[1]};
        logic [PM_W-1:0]     w_c0;
        logic [PM_W-1:0]     w_c1;
        logic                w_sel;
        logic [TB_DEPTH-1:0] w_surv;

        assign w_c0          = sat_add(r_pm[P0], branch_metric(P0, NS[0], r_r0, din));
        assign w_c1          = sat_add(r_pm[P1], branch_metric(P1, NS[0], r_r0, din));
        assign w_sel         = (w_c1 < w_c0);
        assign w_pm_raw[g]   = w_sel ? w_c1 : w_c0;
        assign w_surv        = w_sel ? r_path[P1] : r_path[P0];
        assign w_path_new[g] = {w_surv[TB_DEPTH-2:0], NS[0]};
    end

    always_comb begin
        w_pm_min = w_pm_raw[0];
        w_best   = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (w_pm_raw[i] < w_pm_min) begin
                w_pm_min = w_pm_raw[i];
                w_best   = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            w_pm_new[i] = w_pm_raw[i] - w_pm_min;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase      <= 1'b0;
            r_r0         <= 1'b0;
            r_sym_cnt    <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_pm[i]   <= (i == 0) ? '0 : PM_MAX;
                r_path[i] <= '0;
            end
        end else begin
            r_dout_valid <= w_emit;
            if (w_emit) begin
                r_dout <= w_path_new[w_best][TB_DEPTH-1];
            end
            if (w_restart) begin
                // A new frame drops any half pair and restarts from state 0.
                r_r0      <= din;
                r_phase   <= 1'b1;
                r_sym_cnt <= '0;
                for (int i = 0; i < 4; i++) begin
                    r_pm[i]   <= (i == 0) ? '0 : PM_MAX;
                    r_path[i] <= '0;
                end
            end else if (din_valid) begin
                if (!r_phase) begin
                    r_r0    <= din;
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        r_pm[i]   <= w_pm_new[i];
                        r_path[i] <= w_path_new[i];
                    end
                    if (r_sym_cnt != CNT_W'(TB_DEPTH)) begin
                        r_sym_cnt <= r_sym_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule
